// File: rtl/seq_count_3b_bin_up_dn_pkg.sv
// Shared constants and the direction encoding for the 3-bit up/down counter.
package seq_count_3b_bin_up_dn_pkg;

  localparam int COUNT_W = 3;
  localparam logic [COUNT_W-1:0] COUNT_RESET = 3'd0;
  localparam logic [COUNT_W-1:0] COUNT_ONE   = 3'd1;

  typedef enum logic {
    UP = 1'b0,
    DN = 1'b1
  } dir_e;

  // Modulo-8 step; the carry or borrow out of the top bit is simply dropped.
  function automatic logic [COUNT_W-1:0] stepCount(input logic [COUNT_W-1:0] cnt,
                                                   input dir_e dir);
    return (dir == DN) ? (cnt - COUNT_ONE) : (cnt + COUNT_ONE);
  endfunction

endpackage

// File: rtl/seq_count_3b_bin_up_dn_if.sv
// Direction-select input and count output of the counter, bundled for the parent.
interface seq_count_3b_bin_up_dn_if;
  import seq_count_3b_bin_up_dn_pkg::*;

  logic               op;
  logic [COUNT_W-1:0] out;

  modport master (output op, input out);
  modport slave  (input op, output out);

endinterface

// File: rtl/seq_count_3b_bin_up_dn.sv
// 3-bit binary counter stepping up (op=0) or down (op=1) on every clock edge, wrapping mod 8.
module seq_count_3b_bin_up_dn
  import seq_count_3b_bin_up_dn_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  seq_count_3b_bin_up_dn_if.slave bus
);

  logic [COUNT_W-1:0] r_cnt;
  logic [COUNT_W-1:0] w_cntNext;

  always_comb begin
    w_cntNext = stepCount(r_cnt, dir_e'(bus.op));
  end

  // No enable: the count moves on every edge once reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= COUNT_RESET;
    end else begin
      r_cnt <= w_cntNext;
    end
  end

  assign bus.out = r_cnt;

endmodule

// File: tb/tb_seq_count_3b_bin_up_dn.sv
// Bench for the 3-bit up/down counter: directed vector table followed by randomized runs against a model.
module tb_seq_count_3b_bin_up_dn;

  logic clk;
  logic reset;
  int   nTests;
  int   nFail;

  seq_count_3b_bin_up_dn_if bus();

  seq_count_3b_bin_up_dn dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       op;
    logic [2:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic r, input logic o, input int e, input string n);
    vec_t v;
    v.rst  = r;
    v.op   = o;
    v.exp  = 3'(e);
    v.name = n;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic r, input logic o);
    @(negedge clk);
    reset  = r;
    bus.op = o;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] exp);
    nTests++;
    if (bus.out !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: out=%0d expected=%0d at t=%0t", name, bus.out, exp, $time);
    end
  endtask

  int mixOp [22] = '{0,0,0,0,1,1,0,0,0,0,1,1,0,0,0,0,1,1,1,1,1,1};
  int mixExp[22] = '{0,1,2,3,4,3,2,3,4,5,6,5,4,5,6,7,0,7,6,5,4,3};

  initial begin
    int  model;
    logic r;
    logic o;

    nTests = 0;
    nFail  = 0;
    reset  = 1'b1;
    bus.op = 1'b0;

    // Expected values are the count seen just before the edge that consumes op.
    addVec(1, 0, 0, "upRst");
    for (int i = 0; i < 5; i++) addVec(0, 0, i, "up");
    addVec(1, 0, 0, "upWrapRst");
    for (int i = 0; i < 20; i++) addVec(0, 0, i % 8, "upWrap");
    addVec(1, 1, 0, "dnWrapRst");
    for (int i = 0; i < 20; i++) addVec(0, 1, (8 - (i % 8)) % 8, "dnWrap");
    addVec(1, 0, 0, "mixRst");
    for (int i = 0; i < 22; i++) addVec(0, 1'(mixOp[i]), mixExp[i], "mixed");
    addVec(1, 0, 0, "midRst0");
    for (int i = 0; i < 4; i++) addVec(0, 0, i, "midUp1");
    for (int i = 0; i < 3; i++) addVec(1, 1, 0, "midRst1");
    for (int i = 0; i < 4; i++) addVec(0, 1, (8 - i) % 8, "midDn");
    for (int i = 0; i < 3; i++) addVec(1, 0, 0, "midRst2");
    for (int i = 0; i < 4; i++) addVec(0, 0, i, "midUp2");

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].op);
      checkOutput(vecs[k].name, vecs[k].exp);
    end

    // Random phase: model holds the count expected before the coming edge.
    applyStimulus(1'b1, 1'b0);
    checkOutput("rndRst", 3'd0);
    model = 0;
    for (int i = 0; i < 100; i++) begin
      r = (i >= 50) && ($urandom_range(3) == 0);
      o = 1'($urandom_range(1));
      applyStimulus(r, o);
      if (r) model = 0;
      checkOutput(r ? "rndReset" : "rndCount", 3'(model));
      if (!r) model = (model + (o ? 7 : 1)) % 8;
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
